// File: rtl/seq_gen_8.sv
// Serial pattern transmitter with CAN-style bit stuffing; MSB first, each bit held
// BIT_CYCLES clocks. Counterpart of the serial sequence detector for loopback tests.
module seq_gen_8 #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STUFF_LEN  = 5,
  parameter int unsigned BIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic             start,
  output logic             dout,
  output logic             busy,
  output logic             stuffed,
  output logic             done
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CycW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned RunW = $clog2(STUFF_LEN) + 1;

  typedef enum logic [1:0] {StIdle, StSend, StStuff, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  pat_q;
  logic [WIDTH-1:0]  frm_q;
  logic [IdxW-1:0]   idx_q;
  logic [CycW-1:0]   cyc_q;
  logic [RunW-1:0]   run_q;

  logic              bit_end;
  logic              last_bit;
  logic [IdxW-1:0]   idx_nxt;
  logic              nxt_bit;
  logic [RunW-1:0]   run_nxt;
  logic [WIDTH-1:0]  src_pat;

  always_comb begin
    bit_end  = (cyc_q == CycW'(BIT_CYCLES - 1));
    last_bit = (idx_q == '0);
    idx_nxt  = idx_q - IdxW'(1);
    nxt_bit  = frm_q[idx_nxt];
    // dout still holds the bit just finished, so it is the run reference
    run_nxt  = (nxt_bit == dout) ? run_q + RunW'(1) : RunW'(1);
    src_pat  = load ? pattern : pat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      frm_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      run_q   <= '0;
      dout    <= 1'b1;
      busy    <= 1'b0;
      stuffed <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          dout    <= 1'b1;
          busy    <= 1'b0;
          stuffed <= 1'b0;
          if (load) pat_q <= pattern;
          if (start) begin
            state_q <= StSend;
            frm_q   <= src_pat;
            idx_q   <= IdxW'(WIDTH - 1);
            cyc_q   <= '0;
            run_q   <= RunW'(1);
            dout    <= src_pat[WIDTH-1];
            busy    <= 1'b1;
          end
        end

        StSend: begin
          if (!bit_end) begin
            cyc_q <= cyc_q + CycW'(1);
          end else begin
            cyc_q <= '0;
            if (run_q == RunW'(STUFF_LEN)) begin
              state_q <= StStuff;
              dout    <= ~dout;
              stuffed <= 1'b1;
              run_q   <= RunW'(1);
            end else if (last_bit) begin
              state_q <= StDone;
              dout    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx_q <= idx_nxt;
              dout  <= nxt_bit;
              run_q <= run_nxt;
            end
          end
        end

        StStuff: begin
          if (!bit_end) begin
            cyc_q <= cyc_q + CycW'(1);
          end else begin
            cyc_q   <= '0;
            stuffed <= 1'b0;
            if (last_bit) begin
              state_q <= StDone;
              dout    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= StSend;
              idx_q   <= idx_nxt;
              dout    <= nxt_bit;
              run_q   <= run_nxt;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
          run_q   <= '0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_8.sv
// Self-checking bench for seq_gen_8: directed and random frames against a bit-list model.
module tb_seq_gen_8;

  localparam int W  = 8;
  localparam int SL = 5;
  localparam int BC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] pattern = '0;
  logic         dout, busy, stuffed, done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  bit           exp_bits[$];
  bit           exp_stf[$];
  logic [W-1:0] pat_model = '0;

  seq_gen_8 #(.WIDTH(W), .STUFF_LEN(SL), .BIT_CYCLES(BC)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .pattern (pattern),
    .start   (start),
    .dout    (dout),
    .busy    (busy),
    .stuffed (stuffed),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected on-wire bit list: data MSB first, complement inserted after every run of SL.
  function automatic void build(input logic [W-1:0] p);
    int run;
    bit last;
    exp_bits.delete();
    exp_stf.delete();
    run = 0;
    last = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      bit b;
      b = p[i];
      if (run > 0 && b == last) run++;
      else run = 1;
      last = b;
      exp_bits.push_back(b);
      exp_stf.push_back(1'b0);
      if (run == SL) begin
        last = ~b;
        run = 1;
        exp_bits.push_back(last);
        exp_stf.push_back(1'b1);
      end
    end
  endfunction

  task automatic kick(input logic [W-1:0] p, input bit use_load);
    pattern = p;
    load    = use_load;
    start   = 1'b1;
    if (use_load) pat_model = p;
    build(pat_model);
    @(posedge clk); #1;
    load  = 1'b0;
    start = 1'b0;
  endtask

  // Called one step after the edge that put the DUT in its first bit.
  task automatic frame(input string tag, input int inj, input logic [W-1:0] inj_pat);
    int cyc, busy_seen, d0;
    cyc = 0;
    busy_seen = 0;
    d0 = done_cnt;
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int c = 0; c < BC; c++) begin
        if (cyc == inj) begin
          load = 1'b1; start = 1'b1; pattern = inj_pat;
        end else if (cyc == inj + 1) begin
          load = 1'b0; start = 1'b0;
        end
        @(negedge clk);
        chk({tag, ".dout"}, 32'(dout), 32'(exp_bits[b]));
        chk({tag, ".stuffed"}, 32'(stuffed), 32'(exp_stf[b]));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        if (busy === 1'b1) busy_seen++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    chk({tag, ".done_dout"}, 32'(dout), 32'd1);
    chk({tag, ".done_stuffed"}, 32'(stuffed), 32'd0);
    chk({tag, ".busy_len"}, 32'(busy_seen), 32'(exp_bits.size() * BC));
    @(posedge clk); #1;
    chk({tag, ".done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, ".idle_dout"}, 32'(dout), 32'd1);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    logic [W-1:0] p;
    bit ul;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.dout", 32'(dout), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.stuffed", 32'(stuffed), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_chk("post_rst");

    // Directed frames
    kick(8'hA5, 1'b1); frame("a5", -10, '0); idle_chk("a5");
    kick(8'h00, 1'b1); frame("00", -10, '0); idle_chk("00");
    kick(8'h1F, 1'b1); frame("1f", -10, '0); idle_chk("1f");

    // start held high: FF then 07 back-to-back
    d0 = done_cnt;
    pattern = 8'hFF; load = 1'b1; start = 1'b1; pat_model = 8'hFF; build(pat_model);
    @(posedge clk); #1;
    load = 1'b0;
    frame("ff", -10, '0);
    pattern = 8'h07; load = 1'b1; pat_model = 8'h07; build(pat_model);
    @(negedge clk);
    chk("ff07.gap_busy", 32'(busy), 32'd0);
    chk("ff07.gap_dout", 32'(dout), 32'd1);
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    frame("07", -10, '0);
    chk("ff07.done_pulses", 32'(done_cnt - d0), 32'd2);
    idle_chk("07");

    // load/start mid-frame are ignored; register keeps 3C
    kick(8'h3C, 1'b1);
    frame("ign", 5, 8'hC3);
    repeat (3) idle_chk("ign");
    kick(8'h5A, 1'b0);
    frame("ign_resend", -10, '0);

    // Random frames, optionally preloading via a load-only cycle
    for (int n = 0; n < 10; n++) begin
      p  = W'($urandom);
      ul = 1'($urandom_range(0, 1));
      if (!ul) begin
        pattern = W'($urandom); load = 1'b1; pat_model = pattern;
        @(posedge clk); #1;
        load = 1'b0;
      end
      kick(p, ul);
      frame("rnd", -10, '0);
      repeat ($urandom_range(0, 2)) idle_chk("rnd");
    end

    // Asynchronous reset during bit 3
    kick(8'hB6, 1'b1);
    d0 = done_cnt;
    repeat (3 * BC) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.dout", 32'(dout), 32'd1);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.stuffed", 32'(stuffed), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_chk("arst");
    chk("arst.no_done", 32'(done_cnt - d0), 32'd0);
    pat_model = '0;
    kick(8'hFF, 1'b0);
    frame("arst_zero", -10, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
